// File: rtl/cmd_arbiter.sv
// Two-requester round-robin command arbiter. It forwards whole packets from the
// owning requester onto a broadcast command bus for the voice FSMs.
module cmd_arbiter #(
  parameter int SET_LEN  = 56,
  parameter int FREQ_LEN = 6
) (
  input  logic        clk147,
  input  logic        rst_n,
  input  logic [31:0] src0_data,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [31:0] src1_data,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [31:0] cmd_data,
  output logic        cmd_data_valid,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err_opcode
);

  localparam int MAX_LEN = (SET_LEN > FREQ_LEN) ? SET_LEN : FREQ_LEN;
  localparam int CNT_W   = ($clog2(MAX_LEN + 1) < 6) ? 6 : $clog2(MAX_LEN + 1);

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_SET      = 4'd1;
  localparam logic [3:0] OP_TOGGLE   = 4'd2;
  localparam logic [3:0] OP_SET_FREQ = 4'd3;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  state_t           state_r;
  logic             rr_ptr_r;
  logic [1:0]       grant_r;
  logic             src0_ready_r;
  logic             src1_ready_r;
  logic             hdr_phase_r;
  logic             fwd_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      cmd_data_r;
  logic             cmd_data_valid_r;
  logic             err_opcode_r;
  logic             busy_r;

  logic [31:0]      sel_data_s;
  logic             acc_s;
  logic             pick_s;
  logic [3:0]       opcode_s;
  logic             mask_nz_s;
  logic [CNT_W-1:0] hdr_len_m1_s;
  logic             hdr_fwd_s;
  logic             hdr_bad_s;
  logic             fwd_now_s;
  logic             last_s;
  logic             err_now_s;

  // Arbitration choice plus header decode of the granted requester's word.
  always_comb begin
    sel_data_s   = grant_r[1] ? src1_data : src0_data;
    acc_s        = (src0_ready_r & src0_valid) | (src1_ready_r & src1_valid);
    opcode_s     = sel_data_s[31:28];
    mask_nz_s    = |sel_data_s[27:20];
    pick_s       = 1'b0;
    hdr_len_m1_s = {CNT_W{1'b0}};
    hdr_fwd_s    = 1'b0;
    hdr_bad_s    = 1'b0;
    fwd_now_s    = 1'b0;
    last_s       = 1'b0;
    err_now_s    = 1'b0;
    if (src0_valid && src1_valid) begin
      pick_s = rr_ptr_r;
    end else if (src1_valid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    case (opcode_s)
      OP_NOP, OP_TOGGLE: begin
        hdr_fwd_s = 1'b1;
      end
      OP_SET: begin
        hdr_len_m1_s = CNT_W'(SET_LEN);
        hdr_fwd_s    = mask_nz_s;
      end
      OP_SET_FREQ: begin
        hdr_len_m1_s = CNT_W'(FREQ_LEN);
        hdr_fwd_s    = mask_nz_s;
      end
      default: begin
        hdr_bad_s = 1'b1;
      end
    endcase
    // Empty-mask packets are still length-tracked so their payload is swallowed.
    if (hdr_phase_r) begin
      fwd_now_s = hdr_fwd_s;
      last_s    = hdr_bad_s | (hdr_len_m1_s == {CNT_W{1'b0}});
      err_now_s = hdr_bad_s;
    end else begin
      fwd_now_s = fwd_r;
      last_s    = (cnt_r == CNT_W'(1));
      err_now_s = 1'b0;
    end
  end

  // Packet ownership FSM with registered handshake and output path.
  always_ff @(posedge clk147 or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      rr_ptr_r         <= 1'b0;
      grant_r          <= 2'b00;
      src0_ready_r     <= 1'b0;
      src1_ready_r     <= 1'b0;
      hdr_phase_r      <= 1'b1;
      fwd_r            <= 1'b0;
      cnt_r            <= {CNT_W{1'b0}};
      cmd_data_r       <= 32'h0000_0000;
      cmd_data_valid_r <= 1'b0;
      err_opcode_r     <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      cmd_data_valid_r <= 1'b0;
      err_opcode_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (src0_valid || src1_valid) begin
            state_r      <= ST_PKT;
            busy_r       <= 1'b1;
            grant_r      <= pick_s ? 2'b10 : 2'b01;
            src0_ready_r <= ~pick_s;
            src1_ready_r <= pick_s;
            hdr_phase_r  <= 1'b1;
          end
        end
        ST_PKT: begin
          if (acc_s) begin
            if (fwd_now_s) begin
              cmd_data_r       <= sel_data_s;
              cmd_data_valid_r <= 1'b1;
            end
            err_opcode_r <= err_now_s;
            if (hdr_phase_r) begin
              cnt_r       <= hdr_len_m1_s;
              fwd_r       <= hdr_fwd_s;
              hdr_phase_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
            if (last_s) begin
              state_r      <= ST_IDLE;
              busy_r       <= 1'b0;
              grant_r      <= 2'b00;
              src0_ready_r <= 1'b0;
              src1_ready_r <= 1'b0;
              rr_ptr_r     <= ~grant_r[1];
              hdr_phase_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign src0_ready     = src0_ready_r;
  assign src1_ready     = src1_ready_r;
  assign cmd_data       = cmd_data_r;
  assign cmd_data_valid = cmd_data_valid_r;
  assign grant          = grant_r;
  assign busy           = busy_r;
  assign err_opcode     = err_opcode_r;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: expected words are queued as stimulus is
// issued and popped as the arbiter emits them on cmd_data.
module tb_cmd_arbiter;

  logic        clk147;
  logic        rst_n;
  logic [31:0] src0_data;
  logic        src0_valid;
  logic        src0_ready;
  logic [31:0] src1_data;
  logic        src1_valid;
  logic        src1_ready;
  logic [31:0] cmd_data;
  logic        cmd_data_valid;
  logic [1:0]  grant;
  logic        busy;
  logic        err_opcode;

  int n_chk;
  int n_pass;
  int err_cnt;
  int cyc_cnt;
  logic [31:0] exp_q[$];
  int          out_cyc[$];

  cmd_arbiter #(.SET_LEN(56), .FREQ_LEN(6)) dut (
    .clk147(clk147), .rst_n(rst_n),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .cmd_data(cmd_data), .cmd_data_valid(cmd_data_valid),
    .grant(grant), .busy(busy), .err_opcode(err_opcode)
  );

  initial clk147 = 1'b0;
  always #5 clk147 = ~clk147;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk147) begin
    cyc_cnt++;
    if (rst_n) begin
      if (err_opcode) err_cnt++;
      if (cmd_data_valid) begin
        out_cyc.push_back(cyc_cnt);
        if (exp_q.size() == 0) check("spurious_out", {31'd0, cmd_data_valid}, 32'd0);
        else check("cmd_data", cmd_data, exp_q.pop_front());
      end
    end
  end

  task automatic set_src(input int s, input logic v, input logic [31:0] d);
    if (s == 0) begin src0_valid = v; src0_data = d; end
    else begin src1_valid = v; src1_data = d; end
  endtask

  // Presents words with optional random gaps; returns #1 after the last acceptance.
  task automatic drive(input int s, input logic [31:0] w[$], input int gap_pct);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    bit  v;
    while (i < w.size() && cyc < 3000) begin
      v = (i == 0) || ($urandom_range(99) >= gap_pct);
      set_src(s, v, w[i]);
      @(negedge clk147);
      acc = v && ((s == 0) ? src0_ready : src1_ready);
      @(posedge clk147);
      #1;
      cyc++;
      if (acc) i++;
    end
    set_src(s, 1'b0, 32'h0);
    if (cyc >= 3000) check("drive_timeout", i, w.size());
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_src(0, 1'b0, 32'h0);
    set_src(1, 1'b0, 32'h0);
    repeat (3) @(posedge clk147);
    @(negedge clk147);
    rst_n = 1'b1;
    exp_q.delete();
    out_cyc.delete();
    err_cnt = 0;
    @(posedge clk147);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk147);
      n++;
    end
    @(posedge clk147);
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  logic [31:0] p0[$];
  logic [31:0] p1[$];

  initial begin
    n_chk = 0; n_pass = 0; err_cnt = 0; cyc_cnt = 0;
    rst_n = 1'b1;
    src0_data = 32'h0; src0_valid = 1'b0; src1_data = 32'h0; src1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", grant, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ready", {src1_ready, src0_ready}, 32'd0);
    check("rst_out", {cmd_data_valid, err_opcode}, 32'd0);
    check("rst_data", cmd_data, 32'd0);
    apply_reset();

    // Scenario 1: SET_FREQ packet from src0 alone.
    p0.delete();
    p0.push_back(32'h3010_0000);
    for (int i = 0; i < 6; i++) p0.push_back(32'hA000_0000 + i);
    foreach (p0[i]) exp_q.push_back(p0[i]);
    fork
      drive(0, p0, 0);
      begin
        @(posedge clk147); #1;
        check("s1_grant", grant, 32'd1);
        check("s1_busy", busy, 32'd1);
      end
    join
    check("s1_busy_fall", busy, 32'd0);
    wait_drain();
    check("s1_out_count", out_cyc.size(), 32'd7);
    check("s1_hold", cmd_data, 32'hA000_0005);
    check("s1_hold_v", cmd_data_valid, 32'd0);

    // Scenario 2: both requesters valid together with one-word packets.
    apply_reset();
    p0.delete(); p1.delete();
    p0.push_back(32'h2010_0000);
    p1.push_back(32'h2010_0001);
    exp_q.push_back(p0[0]);
    exp_q.push_back(p1[0]);
    fork
      drive(0, p0, 0);
      drive(1, p1, 0);
      begin
        @(posedge clk147); #1;
        check("s2_grant0", grant, 32'd1);
      end
    join
    wait_drain();
    check("s2_out_count", out_cyc.size(), 32'd2);
    if (out_cyc.size() == 2) check("s2_dead_cycle", out_cyc[1] - out_cyc[0], 32'd2);

    // Scenario 3: long src1 packet with gaps while src0 keeps asking.
    apply_reset();
    p0.delete(); p1.delete();
    p1.push_back(32'h1030_0000);
    for (int i = 0; i < 56; i++) p1.push_back(32'hB100_0000 + i);
    p0.push_back(32'h2040_0000);
    foreach (p1[i]) exp_q.push_back(p1[i]);
    exp_q.push_back(p0[0]);
    fork
      drive(1, p1, 30);
      begin
        @(posedge clk147); #1;
        check("s3_grant1", grant, 32'd2);
        drive(0, p0, 0);
      end
    join
    wait_drain();
    check("s3_out_count", out_cyc.size(), 32'd58);

    // Scenario 4: bad opcode, then an empty-mask SET packet.
    apply_reset();
    p0.delete();
    p0.push_back(32'h5010_0000);
    p0.push_back(32'h1000_0000);
    for (int i = 0; i < 56; i++) p0.push_back(32'hD000_0000 + i);
    drive(0, p0, 10);
    check("s4_busy", busy, 32'd0);
    repeat (3) @(posedge clk147);
    #1;
    check("s4_err_cnt", err_cnt, 32'd1);
    check("s4_no_out", out_cyc.size(), 32'd0);

    // Scenario 5: reset during the 20th payload word.
    apply_reset();
    p0.delete();
    p0.push_back(32'h1010_0000);
    for (int i = 0; i < 19; i++) p0.push_back(32'hC000_0000 + i);
    foreach (p0[i]) exp_q.push_back(p0[i]);
    drive(0, p0, 0);
    set_src(0, 1'b1, 32'hC000_0013);
    @(negedge clk147);
    #1;
    check("s5_pre_drain", exp_q.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    check("s5_rst_grant", grant, 32'd0);
    check("s5_rst_busy", busy, 32'd0);
    check("s5_rst_ready", {src1_ready, src0_ready}, 32'd0);
    check("s5_rst_valid", cmd_data_valid, 32'd0);
    check("s5_rst_data", cmd_data, 32'd0);
    set_src(0, 1'b0, 32'h0);
    repeat (2) @(posedge clk147);
    @(negedge clk147);
    rst_n = 1'b1;
    @(posedge clk147);
    #1;
    p1.delete();
    p1.push_back(32'h2020_0000);
    exp_q.push_back(p1[0]);
    drive(1, p1, 0);
    wait_drain();
    check("s5_idle", busy, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
